// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small byte FIFO exposed as one 16-bit status/data word.
// Latency: 2-cycle pin synchronizer; byte visible right after the stop-bit sample edge.
// Backpressure: none on the line; a byte arriving while the FIFO is full is dropped and flagged as overflow.
module uart_rx #(
    parameter int CLOCKS_PER_BIT  = 104,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        pop,
    input  logic        clear_errors,
    output logic [15:0] data_out,
    output logic        rx_busy
);
    localparam int CW    = $clog2(CLOCKS_PER_BIT);
    localparam int L     = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << L;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t         state, state_n;
    logic           rx_meta, rxs;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic [7:0]     sh;
    logic           push, frame_err, shift_en, clr_idx;

    logic [7:0]     mem [DEPTH];
    logic [L-1:0]   wptr, rptr;
    logic [L:0]     count;
    logic           ovf, ferr;
    logic           valid, full, do_pop, do_push, ovf_evt;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic and per-cycle strobes; every sample happens at cnt==0
    always_comb begin
        state_n   = state;
        push      = 1'b0;
        frame_err = 1'b0;
        shift_en  = 1'b0;
        clr_idx   = 1'b0;
        case (state)
            IDLE:  if (!rxs) state_n = START;
            START: if (cnt == '0) begin
                       if (!rxs) begin
                           clr_idx = 1'b1;
                           state_n = DATA;
                       end else begin
                           state_n = IDLE;
                       end
                   end
            DATA:  if (cnt == '0) begin
                       shift_en = 1'b1;
                       if (idx == 3'd7) state_n = STOP;
                   end
            STOP:  if (cnt == '0) begin
                       if (rxs) begin
                           push    = 1'b1;
                           state_n = IDLE;
                       end else begin
                           frame_err = 1'b1;
                           state_n   = BRK;
                       end
                   end
            BRK:   if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bit timer: half-bit load on start edge puts every later sample at mid-bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       cnt <= '0;
        else if (state == IDLE && !rxs)   cnt <= CW'(CLOCKS_PER_BIT / 2 - 1);
        else if (cnt == '0)               cnt <= CW'(CLOCKS_PER_BIT - 1);
        else                              cnt <= cnt - CW'(1);
    end

    // LSB-first shift register and bit index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh  <= '0;
            idx <= '0;
        end else if (clr_idx) begin
            idx <= '0;
        end else if (shift_en) begin
            sh  <= {rxs, sh[7:1]};
            idx <= idx + 3'd1;
        end
    end

    assign valid   = (count != '0);
    assign full    = (count == (L+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign ovf_evt = push && full && !do_pop;

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= sh;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + L'(1);
            if (do_pop)  rptr <= rptr + L'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (L+1)'(1);
                2'b01:   count <= count - (L+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error bits; a same-cycle error event beats clear_errors
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovf_evt)           ovf  <= 1'b1;
            else if (clear_errors) ovf  <= 1'b0;
            if (frame_err)         ferr <= 1'b1;
            else if (clear_errors) ferr <= 1'b0;
        end
    end

    assign data_out = {valid, ovf, ferr, 5'b0, valid ? mem[rptr] : 8'h00};
    assign rx_busy  = (state != IDLE);

endmodule
